// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register plus IF/ID pipeline register with RUN/STALL/FLUSH control.
// Optional build macro IF_STAGE_PERF_CNT_EN adds fetch_count / stall_count performance counters.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   input  logic [31:0] instr_in,
   output logic [31:0] pc_out,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_instr,
`ifdef IF_STAGE_PERF_CNT_EN
   output logic [31:0] fetch_count,
   output logic [31:0] stall_count,
`endif
   output logic        if_id_valid
);

   typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

   state_t      state, mode;
   logic [31:0] pc, pc_plus4;

   assign pc_plus4 = pc + 32'd4;
   assign pc_out   = pc;

   // Redirect wins over stall: a taken branch squashes whatever the hazard unit is holding.
   always_comb begin
      mode = RUN;
      if (branch_taken)
         mode = FLUSH;
      else if (freeze)
         mode = STALL;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= RUN;
         pc          <= {RESET_PC[31:2], 2'b00};
         if_id_pc    <= 32'h0;
         if_id_instr <= NOP_INSTR;
         if_id_valid <= 1'b0;
      end else begin
         state <= mode;
         case (mode)
            RUN: begin
               pc          <= pc_plus4;
               if_id_pc    <= pc_plus4;
               if_id_instr <= instr_in;
               if_id_valid <= 1'b1;
            end
            FLUSH: begin
               pc          <= {branch_addr[31:2], 2'b00};
               if_id_pc    <= 32'h0;
               if_id_instr <= NOP_INSTR;
               if_id_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

`ifdef IF_STAGE_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_count <= 32'h0;
         stall_count <= 32'h0;
      end else begin
         if (mode == RUN)   fetch_count <= fetch_count + 32'd1;
         if (mode == STALL) stall_count <= stall_count + 32'd1;
      end
   end
`endif

`ifndef SYNTHESIS
   // A redirect edge always leaves a bubble in IF/ID.
   a_flush_bubble: assert property (@(posedge clk) disable iff (rst)
      (state == FLUSH) |-> !if_id_valid);
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: per-cycle reference model plus directed literal checks.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        freeze = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_addr = 32'h0;
   logic [31:0] instr_in;
   logic [31:0] pc_out, if_id_pc, if_id_instr;
   logic        if_id_valid;
`ifdef IF_STAGE_PERF_CNT_EN
   logic [31:0] fetch_count, stall_count;
`endif

   int errors = 0;
   int checks = 0;

   if_stage dut (
      .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
      .branch_addr(branch_addr), .instr_in(instr_in), .pc_out(pc_out),
      .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
`ifdef IF_STAGE_PERF_CNT_EN
      .fetch_count(fetch_count), .stall_count(stall_count),
`endif
      .if_id_valid(if_id_valid)
   );

   always #5 clk = ~clk;

   // Instruction memory: word at byte address 8 is a fixed known opcode.
   function automatic logic [31:0] imem(input logic [31:0] a);
      if (a == 32'h8) return 32'h0C01_1800;
      return {a[15:0] ^ 16'h1357, a[15:0]};
   endfunction

   assign instr_in = imem(pc_out);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: what the fetch stage must hold after each edge.
   logic [31:0] m_pc, m_ifpc, m_instr, m_fc, m_sc;
   logic        m_valid;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pc = 32'h0; m_ifpc = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
         m_fc = 32'h0; m_sc = 32'h0;
      end else if (branch_taken) begin
         m_pc = branch_addr & ~32'h3;
         m_ifpc = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
      end else if (freeze) begin
         m_sc = m_sc + 1;
      end else begin
         m_instr = imem(m_pc);
         m_pc = m_pc + 4;
         m_ifpc = m_pc; m_valid = 1'b1;
         m_fc = m_fc + 1;
      end
   end

   always @(negedge clk) begin
      chk("model_pc", pc_out, m_pc);
      chk("model_ifpc", if_id_pc, m_ifpc);
      chk("model_instr", if_id_instr, m_instr);
      chk("model_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
`ifdef IF_STAGE_PERF_CNT_EN
      chk("model_fetch_cnt", fetch_count, m_fc);
      chk("model_stall_cnt", stall_count, m_sc);
`endif
   end

   task automatic edge1();
      @(posedge clk); #1;
   endtask

   task automatic set_in(input logic f, input logic b, input logic [31:0] a);
      freeze = f; branch_taken = b; branch_addr = a;
   endtask

   task automatic chk_if(input string n, input logic [31:0] pc, input logic [31:0] ipc,
                         input logic [31:0] ins, input logic v);
      chk({n, "_pc"}, pc_out, pc);
      chk({n, "_ifpc"}, if_id_pc, ipc);
      chk({n, "_instr"}, if_id_instr, ins);
      chk({n, "_valid"}, {31'h0, if_id_valid}, {31'h0, v});
   endtask

   initial begin
      edge1(); edge1();
      chk_if("reset", 32'h0, 32'h0, 32'h0, 1'b0);
      rst = 1'b0;
      edge1(); edge1(); edge1();
      chk_if("run3", 32'd12, 32'd12, 32'h0C01_1800, 1'b1);
      edge1();
      chk("run4_pc", pc_out, 32'd16);
      set_in(1, 0, 0);
      edge1(); edge1();
      chk_if("stall2", 32'd16, 32'd16, imem(32'd12), 1'b1);
      set_in(0, 0, 0);
      edge1();
      chk("unstall_pc", pc_out, 32'd20);
      set_in(1, 1, 32'h0000_00BB);
      edge1();
      chk_if("flush_prio", 32'hB8, 32'h0, 32'h0, 1'b0);
      set_in(0, 0, 0);
      edge1();
      chk_if("after_flush", 32'hBC, 32'hBC, imem(32'hB8), 1'b1);
      set_in(0, 1, 32'h40);
      edge1();
      set_in(0, 1, 32'h83);
      edge1();
      chk_if("b2b_flush", 32'h80, 32'h0, 32'h0, 1'b0);
      set_in(0, 1, 32'hFFFF_FFFF);
      edge1();
      chk("wrap_redirect_pc", pc_out, 32'hFFFF_FFFC);
      set_in(0, 0, 0);
      edge1();
      chk_if("wrap", 32'h0, 32'h0, imem(32'hFFFF_FFFC), 1'b1);
      edge1(); edge1();
      // Async reset mid-stall, checked before any clock edge.
      set_in(1, 0, 0);
      edge1();
      #2 rst = 1'b1; #1;
      chk_if("async_rst_stall", 32'h0, 32'h0, 32'h0, 1'b0);
      edge1(); #2 rst = 1'b0;
      set_in(0, 0, 0);
      edge1();
      chk_if("post_rst_fetch", 32'd4, 32'd4, imem(32'h0), 1'b1);
      set_in(0, 1, 32'h1234);
      #2 rst = 1'b1; #1;
      chk_if("async_rst_flush", 32'h0, 32'h0, 32'h0, 1'b0);
      edge1(); #2 rst = 1'b0;
      // Mixed pattern exercised through the model only.
      for (int i = 0; i < 40; i++) begin
         set_in(i % 5 == 2, i % 7 == 3, 32'h100 + 32'(i * 13));
         edge1();
      end
      set_in(0, 0, 0);
`ifdef IF_STAGE_PERF_CNT_EN
      #2 rst = 1'b1; #1;
      chk("cnt_rst_fetch", fetch_count, 32'h0);
      chk("cnt_rst_stall", stall_count, 32'h0);
      edge1(); #2 rst = 1'b0;
      for (int i = 0; i < 9; i++) begin
         set_in(i >= 5 && i < 8, i == 8, 32'h200);
         edge1();
      end
      set_in(0, 0, 0);
      chk("cnt_fetch5", fetch_count, 32'd5);
      chk("cnt_stall3", stall_count, 32'd3);
      #2 rst = 1'b1; #1;
      chk("cnt_clr_fetch", fetch_count, 32'h0);
      chk("cnt_clr_stall", stall_count, 32'h0);
      edge1(); #2 rst = 1'b0;
`endif
      edge1(); edge1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, instruction word inserted into IF/ID on reset or flush.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port freeze  input  1  hazard stall from hazard unit; hold PC and IF/ID.
REQ-006 Port branch_taken  input  1  redirect request from ID/EX.
REQ-007 Port branch_addr  input  32  redirect target byte address.
REQ-008 Port instr_in  input  32  instruction word returned combinationally by instruction memory for pc_out.
REQ-009 Port pc_out  output  32  current PC, drives instruction memory Address.
REQ-010 Port if_id_pc  output  32  PC+4 of the instruction held in IF/ID.
REQ-011 Port if_id_instr  output  32  instruction held in IF/ID.
REQ-012 Port if_id_valid  output  1  IF/ID holds a real fetched instruction.

Function
REQ-013 The block SHALL hold a 32-bit PC register and a registered IF/ID stage (pc, instr, valid); pc_out SHALL equal the PC register directly.
REQ-014 The block SHALL implement a 3-state FSM: RUN, STALL, FLUSH, updated every rising clk edge.
REQ-015 Next state SHALL be FLUSH if branch_taken=1, else STALL if freeze=1, else RUN; branch_taken SHALL take priority over freeze.
REQ-016 In a RUN cycle the block SHALL load PC<=PC+4, if_id_instr<=instr_in, if_id_pc<=PC+4, if_id_valid<=1.
REQ-017 In a STALL cycle PC, if_id_pc, if_id_instr and if_id_valid SHALL all hold their values.
REQ-018 In a FLUSH cycle the block SHALL load PC<={branch_addr[31:2],2'b00}, if_id_instr<=NOP_INSTR, if_id_pc<=0, if_id_valid<=0.
REQ-019 Fetch latency SHALL be one cycle: the word for pc_out=A appears on if_id_instr after the next RUN edge.
REQ-020 PC+4 SHALL be computed modulo 2^32; PC=32'hFFFF_FFFC SHALL wrap to 32'h0000_0000 with no error indication.
REQ-021 Low two bits of branch_addr SHALL be ignored; pc_out[1:0] SHALL always be 2'b00.
REQ-022 Back-to-back branch_taken cycles SHALL each redirect PC and keep if_id_valid=0.

Reset
REQ-023 While rst=1, regardless of clk: PC=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_valid=0, FSM=RUN.
REQ-024 rst asserted mid-operation (including during STALL or FLUSH) SHALL discard all in-flight state immediately; first RUN edge after release fetches RESET_PC.

Configuration
REQ-025 Macro IF_STAGE_PERF_CNT_EN, when defined, SHALL add outputs fetch_count (32) and stall_count (32), both reset to 0, incrementing modulo 2^32 on each RUN and STALL edge respectively; FLUSH cycles count in neither.
REQ-026 Without IF_STAGE_PERF_CNT_EN the counter ports and logic SHALL not exist; all other behaviour is identical.

Verification
REQ-027 Reset: assert rst asynchronously mid-cycle -> pc_out=0, if_id_instr=0, if_id_valid=0 immediately, without a clk edge.
REQ-028 Free run, real instruction memory, 3 edges after reset release -> pc_out=12, if_id_pc=12, if_id_instr=32'h0C01_1800, if_id_valid=1.
REQ-029 freeze=1 for 2 edges at pc_out=16 -> pc_out stays 16, IF/ID unchanged; after release next edge pc_out=20.
REQ-030 branch_taken=1, branch_addr=32'h0000_00BB, freeze=1 same cycle -> next edge pc_out=32'hB8, if_id_valid=0, if_id_instr=0; following edge pc_out=32'hBC, if_id_pc=32'hBC, if_id_valid=1.
REQ-031 Wrap: redirect to 32'hFFFF_FFFC then one RUN edge -> pc_out=0, if_id_pc=0.
REQ-032 With IF_STAGE_PERF_CNT_EN: 5 RUN, 3 STALL, 1 FLUSH edges -> fetch_count=5, stall_count=3; rst -> both 0.
